// File: rtl/clk_div_meter_if.sv
// Signal bundle between a divided-clock source/checker configuration and clk_div_meter.
// The master side drives the clock under test and expectations; the slave side reports measurements.
interface clk_div_meter_if #(
    parameter int W = 8
);
    logic         enable;
    logic         sig_in;
    logic [W-1:0] exp_period;
    logic [W-1:0] exp_high;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         lock;
    logic         err;
    logic         timeout;
    logic [W-1:0] err_count;

    modport master (
        output enable, sig_in, exp_period, exp_high,
        input  period, high_time, meas_valid, lock, err, timeout, err_count
    );

    modport slave (
        input  enable, sig_in, exp_period, exp_high,
        output period, high_time, meas_valid, lock, err, timeout, err_count
    );
endinterface

// File: rtl/clk_div_meter.sv
// Measures period and high time of a clk_in-derived divided clock, checks them against
// expected values, and reports lock, mismatch/timeout errors and a saturating error count.
module clk_div_meter #(
    parameter int W          = 8,
    parameter int LOCK_COUNT = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_div_meter_if.slave bus
);
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [3:0]   LOCK_N  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    state_t       state_q, state_d;
    logic         s1, s2;
    logic         rise;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hcnt_q, hcnt_d;
    logic [3:0]   match_q, match_d;
    logic [3:0]   match_inc;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         mv_q, mv_d;
    logic         lock_q, lock_d;
    logic         err_q, err_d;
    logic         to_q, to_d;
    logic [W-1:0] ecnt_q, ecnt_d;
    logic [W-1:0] ecnt_inc;
    logic         match;

    assign rise      = s1 & ~s2;
    assign match     = (cnt_q == bus.exp_period) && (hcnt_q == bus.exp_high);
    assign match_inc = (match_q < LOCK_N) ? 4'(match_q + 4'd1) : match_q;
    assign ecnt_inc  = (ecnt_q == CNT_MAX) ? ecnt_q : ecnt_q + W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        match_d  = match_q;
        period_d = period_q;
        high_d   = high_q;
        mv_d     = 1'b0;
        lock_d   = lock_q;
        err_d    = 1'b0;
        to_d     = to_q;
        ecnt_d   = ecnt_q;

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            match_d = '0;
            lock_d  = 1'b0;
            to_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    match_d = '0;
                    lock_d  = 1'b0;
                    state_d = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt_d   = W'(1);
                        hcnt_d  = W'(1);
                        to_d    = 1'b0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the cnt==CNT_MAX cycle is a valid full-range measurement.
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        mv_d     = 1'b1;
                        cnt_d    = W'(1);
                        hcnt_d   = W'(1);
                        if (match) begin
                            match_d = match_inc;
                            lock_d  = (match_inc == LOCK_N);
                        end else begin
                            err_d   = 1'b1;
                            ecnt_d  = ecnt_inc;
                            match_d = '0;
                            lock_d  = 1'b0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        to_d    = 1'b1;
                        ecnt_d  = ecnt_inc;
                        match_d = '0;
                        lock_d  = 1'b0;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                        state_d = WAIT_EDGE;
                    end else begin
                        cnt_d  = cnt_q + W'(1);
                        hcnt_d = hcnt_q + W'(s1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            match_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            mv_q     <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            s1       <= bus.sig_in;
            s2       <= s1;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            match_q  <= match_d;
            period_q <= period_d;
            high_q   <= high_d;
            mv_q     <= mv_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
            to_q     <= to_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = mv_q;
    assign bus.lock       = lock_q;
    assign bus.err        = err_q;
    assign bus.timeout    = to_q;
    assign bus.err_count  = ecnt_q;
endmodule

// File: tb/tb_clk_div_meter.sv
// Directed and randomized divided-clock waveforms against an event-level reference model:
// measurements are derived from the sample indices of rising edges and the samples between them.
module tb_clk_div_meter;
    localparam int W          = 8;
    localparam int LOCK_COUNT = 2;
    localparam int CNT_MAX    = 255;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    clk_div_meter_if #(.W(W)) bif ();

    clk_div_meter #(.W(W), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bif)
    );

    always #5 clk_in = ~clk_in;

    int nchk = 0;
    int nerr = 0;

    // Reference model state
    bit hist[$];   // sample taken at edge t lives at index t+1
    int t;
    int phase;     // 0 off, 1 waiting for first rise, 2 measuring
    int ref_r;     // sample index of last reference rise
    int runs;
    int m_period, m_high, m_ecnt;
    bit m_mv, m_lock, m_err, m_to;

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        t = 0; phase = 0; ref_r = 0; runs = 0;
        m_period = 0; m_high = 0; m_ecnt = 0;
        m_mv = 0; m_lock = 0; m_err = 0; m_to = 0;
    endtask

    task automatic bump_err();
        m_err = 1;
        if (m_ecnt < CNT_MAX) m_ecnt++;
        runs = 0;
        m_lock = 0;
    endtask

    // Called at each active edge with the inputs the DUT just sampled.
    task automatic model_step();
        bit rise;
        int p, hs;
        t++;
        rise = (hist[t] == 1'b1) && (hist[t-1] == 1'b0);
        m_mv = 0;
        m_err = 0;
        if (!bif.enable) begin
            phase = 0; m_lock = 0; m_to = 0; runs = 0;
        end else if (phase == 0) begin
            phase = 1;
        end else if (phase == 1) begin
            if (rise) begin
                ref_r = t - 1; m_to = 0; phase = 2;
            end
        end else begin
            p = (t - 1) - ref_r;
            if (rise) begin
                hs = 0;
                for (int i = ref_r; i <= t - 2; i++) hs += int'(hist[i+1]);
                m_period = p;
                m_high = hs;
                m_mv = 1;
                if (p == int'(bif.exp_period) && hs == int'(bif.exp_high)) begin
                    if (runs < LOCK_COUNT) runs++;
                    m_lock = (runs == LOCK_COUNT);
                end else begin
                    bump_err();
                end
                ref_r = t - 1;
            end else if (p == CNT_MAX) begin
                bump_err();
                m_to = 1;
                phase = 1;
            end
        end
        hist.push_back(bif.sig_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("period",     32'(bif.period),     32'(m_period));
        chk("high_time",  32'(bif.high_time),  32'(m_high));
        chk("meas_valid", 32'(bif.meas_valid), 32'(m_mv));
        chk("lock",       32'(bif.lock),       32'(m_lock));
        chk("err",        32'(bif.err),        32'(m_err));
        chk("timeout",    32'(bif.timeout),    32'(m_to));
        chk("err_count",  32'(bif.err_count),  32'(m_ecnt));
    endtask

    task automatic cycle(input logic s);
        bif.sig_in = s;
        @(posedge clk_in);
        model_step();
        #1;
        check_all();
    endtask

    task automatic div_run(input int n, input int h, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                cycle(i < h);
    endtask

    task automatic set_exp(input int p, input int h);
        bif.exp_period = W'(p);
        bif.exp_high   = W'(h);
    endtask

    initial begin
        int n, h, reps;
        bif.enable = 1'b0;
        bif.sig_in = 1'b0;
        set_exp(4, 2);
        model_reset();
        #1;
        check_all();
        repeat (3) @(posedge clk_in);
        #1;
        rst = 1'b1;
        model_reset();

        // Divide-by-4 lock
        bif.enable = 1'b1;
        div_run(4, 2, 6);

        // Asynchronous reset mid-cycle while sig_in keeps toggling
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        bif.enable = 1'b0;
        repeat (3) begin
            bif.sig_in = ~bif.sig_in;
            @(posedge clk_in);
        end
        #1;
        rst = 1'b1;
        bif.enable = 1'b1;
        div_run(4, 2, 4);

        // Lock on divide-by-2, then switch to divide-by-8
        set_exp(2, 1);
        div_run(2, 1, 5);
        div_run(8, 4, 3);

        // Lock then hold sig_in low until timeout; next rise only arms
        set_exp(4, 2);
        div_run(4, 2, 4);
        repeat (300) cycle(1'b0);
        div_run(4, 2, 4);

        // Boundary: period 255 is valid, 256 times out
        set_exp(255, 100);
        div_run(255, 100, 3);
        div_run(256, 100, 3);

        // Enable drop mid-measurement
        set_exp(4, 2);
        div_run(4, 2, 4);
        cycle(1'b1);
        bif.enable = 1'b0;
        div_run(4, 2, 2);
        bif.enable = 1'b1;
        div_run(4, 2, 4);

        // Saturate err_count with 300 mismatches
        set_exp(3, 1);
        div_run(2, 1, 302);

        // Randomized divider ratios and expectations
        for (int k = 0; k < 30; k++) begin
            n = $urandom_range(12, 2);
            h = $urandom_range(n - 1, 1);
            reps = $urandom_range(6, 3);
            if ($urandom_range(2, 0) != 0) set_exp(n, h);
            else set_exp($urandom_range(12, 2), $urandom_range(6, 1));
            if ($urandom_range(7, 0) == 0) begin
                bif.enable = 1'b0;
                cycle(1'b0);
                cycle(1'b1);
                bif.enable = 1'b1;
            end
            div_run(n, h, reps);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
